// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit ripple slice reused per clock, LS nibble first.
// Define SUBTRACT_SUPPORT_EN to add the op_sub port (two's-complement A - B).

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
`ifdef SUBTRACT_SUPPORT_EN
   input  logic             op_sub,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             ovf,
   output logic             busy
);
   localparam int N  = WIDTH / 4;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [KW-1:0]    k;
   logic [3:0]       nib_sum;
   logic [4:0]       c_chain;
   logic             sub_sel;

`ifdef SUBTRACT_SUPPORT_EN
   assign sub_sel = op_sub;
`else
   assign sub_sel = 1'b0;
`endif

   // Operands are shifted right each step so the slice always sees bits [3:0].
   assign c_chain[0] = carry;
   for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      full_adder u_fa (
         .a  (a_sh[gi]),
         .b  (b_sh[gi]),
         .ci (c_chain[gi]),
         .s  (nib_sum[gi]),
         .co (c_chain[gi+1])
      );
   end

   assign start_ready = (state == IDLE);
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         carry     <= 1'b0;
         k         <= '0;
         result    <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_sh  <= op_a;
                  b_sh  <= sub_sel ? ~op_b : op_b;
                  carry <= sub_sel;
                  k     <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               result[4*k +: 4] <= nib_sum;
               a_sh  <= a_sh >> 4;
               b_sh  <= b_sh >> 4;
               carry <= c_chain[4];
               k     <= k + 1'b1;
               if (k == KW'(N - 1)) begin
                  // Carry into the MSB is the slice's bit-2 carry on the last step.
                  c_out     <= c_chain[4];
                  ovf       <= c_chain[3] ^ c_chain[4];
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16 and WIDTH=4) with a result scoreboard.
`timescale 1ns/1ps

module tb_nibble_serial_adder_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic        op_sub = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [15:0] result;
   logic        c_out;
   logic        ovf;
   logic        busy;

   logic        start_valid4 = 1'b0;
   logic        start_ready4;
   logic [3:0]  op_a4 = '0;
   logic [3:0]  op_b4 = '0;
   logic        res_valid4;
   logic        res_ready4 = 1'b1;
   logic [3:0]  result4;
   logic        c_out4;
   logic        ovf4;
   logic        busy4;
`ifdef SUBTRACT_SUPPORT_EN
   logic        op_sub4 = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .op_a(op_a), .op_b(op_b),
`ifdef SUBTRACT_SUPPORT_EN
      .op_sub(op_sub),
`endif
      .res_valid(res_valid), .res_ready(res_ready),
      .result(result), .c_out(c_out), .ovf(ovf), .busy(busy)
   );

   nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid4), .start_ready(start_ready4),
      .op_a(op_a4), .op_b(op_b4),
`ifdef SUBTRACT_SUPPORT_EN
      .op_sub(op_sub4),
`endif
      .res_valid(res_valid4), .res_ready(res_ready4),
      .result(result4), .c_out(c_out4), .ovf(ovf4), .busy(busy4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: full-width arithmetic, packed as {ovf, c_out, result}.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
      logic [15:0] bb;
      logic [16:0] s;
      logic        v;
      bb = sub ? ~b : b;
      s  = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
      v  = (a[15] == bb[15]) && (s[15] != a[15]);
      return {v, s[16], s[15:0]};
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_start_ready"}, start_ready, 1);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_c_out"}, c_out, 0);
      check({tag, "_ovf"}, ovf, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input int hold);
      int cyc;
      logic [17:0] e;
      @(negedge clk);
      op_a = a; op_b = b; op_sub = sub; start_valid = 1'b1;
      res_ready = (hold == 0);
      check({tag, "_start_ready"}, start_ready, 1);
      @(posedge clk);
      exp_q.push_back(model(a, b, sub));
      #1 start_valid = 1'b0;
      op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      cyc = 0;
      while (!res_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, cyc, 4);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3ffff;
      check({tag, "_result"}, result, e[15:0]);
      check({tag, "_c_out"}, c_out, e[16]);
      check({tag, "_ovf"}, ovf, e[17]);
      for (int i = 0; i < hold; i++) begin
         if (i == 2) begin
            op_a = 16'h1111; op_b = 16'h2222; start_valid = 1'b1;
         end else begin
            start_valid = 1'b0;
         end
         check({tag, "_hold_start_ready"}, start_ready, 0);
         @(negedge clk);
         check({tag, "_hold_res_valid"}, res_valid, 1);
         check({tag, "_hold_result"}, {ovf, c_out, result}, e);
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      check({tag, "_after_res_valid"}, res_valid, 0);
      check({tag, "_after_start_ready"}, start_ready, 1);
      check({tag, "_after_busy"}, busy, 0);
      $display("op %s: %h %s %h -> result=%h c_out=%0d ovf=%0d latency=%0d",
               tag, a, sub ? "-" : "+", b, result, c_out, ovf, cyc);
   endtask

   initial begin
      int cyc;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 0);
      run_op("add_carry", 16'hFFFF, 16'h0001, 1'b0, 0);
      run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 0);
      run_op("backpress", 16'h8000, 16'h8001, 1'b0, 5);
      run_op("add_mixed", 16'hA5C3, 16'h5A3D, 1'b0, 0);

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      op_a = 16'h1234; op_b = 16'h4321; start_valid = 1'b1;
      @(posedge clk);
      #1 start_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrun_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_values("midrun_reset");
      $display("op midrun_reset: result=%h busy=%0d", result, busy);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_reset", 16'h0003, 16'h0004, 1'b0, 0);

`ifdef SUBTRACT_SUPPORT_EN
      run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 0);
      run_op("sub_plain",  16'h0007, 16'h0005, 1'b1, 0);
`endif

      // WIDTH=4 instance: single-step latency.
      @(negedge clk);
      op_a4 = 4'h9; op_b4 = 4'h8; start_valid4 = 1'b1;
      check("w4_start_ready", start_ready4, 1);
      @(posedge clk);
      #1 start_valid4 = 1'b0;
      @(negedge clk);
      cyc = 0;
      while (!res_valid4 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("w4_latency", cyc, 1);
      check("w4_result", result4, 4'h1);
      check("w4_c_out", c_out4, 1);
      check("w4_ovf", ovf4, 1);
      $display("op w4: 9 + 8 -> result=%h c_out=%0d ovf=%0d latency=%0d", result4, c_out4, ovf4, cyc);
      @(negedge clk);
      check("w4_after_res_valid", res_valid4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that adds two WIDTH-bit operands by time-multiplexing a single 4-bit ripple slice, one nibble per clock, least-significant nibble first. It holds operands, a carry register and result shift state, and wraps the operation in valid/ready handshakes on both sides. It is the area-lean alternative to a full-width ripple adder wherever several cycles of latency are acceptable.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; N = WIDTH/4 nibble steps.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  request carries valid operands.
- start_ready  output  1  block can accept a request (high only in IDLE).
- op_a  input  WIDTH  operand A, sampled on start handshake.
- op_b  input  WIDTH  operand B, sampled on start handshake.
- op_sub  input  1  present only with SUB_EN; 1 = A − B.
- res_valid  output  1  result, c_out and ovf are valid.
- res_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum (or difference) modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB nibble.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN or DONE.

## Operation
- Slice: 4-bit ripple adder with carry-in, built from the team's full_adder cells; the only adder in the block.
- States: IDLE, RUN, DONE.
- IDLE: start_ready = 1. On start_valid & start_ready, capture op_a/op_b (B inverted if op_sub), load carry register with 0 (1 if op_sub), clear step counter k, go to RUN.
- RUN: each cycle the slice adds nibble k of A, nibble k of B and the carry register. The nibble sum is written to result[4k+3:4k], the slice carry-out goes to the carry register, and k increments. When k = N−1, also latch c_out and ovf, then go to DONE.
- DONE: res_valid = 1. result, c_out and ovf are held stable until res_valid & res_ready, then go to IDLE.
- start_valid outside IDLE is ignored and not queued; operand inputs may change freely after capture.
- result retains its last value in IDLE; it is not cleared at a new start until the nibbles are overwritten.
- Reset (any state, including mid-RUN): immediately to IDLE, partial result discarded.

## Timing
- Reset values: start_ready = 1, res_valid = 0, result = 0, c_out = 0, ovf = 0, busy = 0, carry = 0, k = 0.
- Start handshake at edge E0. Nibble k is registered at edge E0+k+1. res_valid rises after edge E0+N. Latency is N cycles (4 for WIDTH = 16; 1 for WIDTH = 4).
- The result handshake occurs at an edge with res_valid & res_ready. start_ready is high from the following cycle, so there are no same-cycle back-to-back requests. Minimum period is N+2 cycles per operation.
- Outputs are all registered except start_ready and busy, which are decoded from state.
- Carry propagates across nibble boundaries only through the carry register, one cycle per boundary.

## Configuration
- SUBTRACT_SUPPORT_EN defined:
  - The op_sub port exists.
  - op_sub = 1 captures ~op_b and an initial carry of 1, giving two's-complement A − B.
  - c_out = 1 means no borrow.
- SUBTRACT_SUPPORT_EN undefined:
  - No op_sub port.
  - Initial carry is always 0 and B is never inverted; the block adds only.

## Test plan
- WIDTH=16, 0x1234 + 0x4321, res_ready=1 → res_valid 4 cycles after the start handshake; result 0x5555, c_out 0, ovf 0.
- 0xFFFF + 0x0001 → result 0x0000, c_out 1, ovf 0 (carry ripples through all 4 nibble steps). 0x7FFF + 0x0001 → 0x8000, c_out 0, ovf 1.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid, then pulse start_valid with new operands → result, c_out and res_valid stay stable, start_ready stays 0, the new request is ignored; release res_ready → IDLE next cycle.
- Assert rst_n=0 during the 2nd RUN cycle → all outputs take reset values asynchronously; after release, 0x0003 + 0x0004 → 0x0007.
- WIDTH=4 instance: 0x9 + 0x8 → result 0x1, c_out 1, ovf 1, latency 1 cycle.
- SUBTRACT_SUPPORT_EN: 0x0005 − 0x0007 → result 0xFFFE, c_out 0; 0x0007 − 0x0005 → result 0x0002, c_out 1.
